// File: rtl/spike_encoder_if.sv
// Spike encoder bus: value handshake toward the encoder and the one-cycle
// spike pulses it emits toward the neuron inputs.
interface spike_encoder_if #(
    parameter int MAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [MAG_W-1:0] in_mag;
    logic             in_sign;
    logic             data_out;
    logic             sign_out;

    modport master (
        output in_valid,
        output in_mag,
        output in_sign,
        input  in_ready,
        input  data_out,
        input  sign_out
    );

    modport slave (
        input  in_valid,
        input  in_mag,
        input  in_sign,
        output in_ready,
        output data_out,
        output sign_out
    );
endinterface

// File: rtl/spike_encoder.sv
// Turns an unsigned magnitude plus polarity into |value| one-cycle spikes,
// each followed by GAP forced-low cycles, then a one-cycle done strobe.
//
// state  | meaning
// S_IDLE | waiting for a value, in_ready high
// S_FIRE | spike cycle, data_out high
// S_GAP  | return-to-zero cycles between spikes
// S_DONE | burst finished, done strobe, may accept the next value
module spike_encoder #(
    parameter int MAG_W = 4,
    parameter int GAP   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    spike_encoder_if.slave  bus,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [MAG_W-1:0] remaining;
    logic [7:0]       gap_cnt;
    logic             sign_q;
    logic             take;

    assign bus.in_ready = ((state == S_IDLE) || (state == S_DONE)) && !flush;
    assign take         = bus.in_valid && bus.in_ready;

    // Outputs are registered from the next state, so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            remaining    <= '0;
            gap_cnt      <= '0;
            sign_q       <= 1'b0;
            bus.data_out <= 1'b0;
            bus.sign_out <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (flush) begin
            state        <= S_IDLE;
            remaining    <= '0;
            gap_cnt      <= '0;
            bus.data_out <= 1'b0;
            bus.sign_out <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            bus.data_out <= 1'b0;
            bus.sign_out <= 1'b0;
            done         <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (take) begin
                        remaining <= bus.in_mag;
                        sign_q    <= bus.in_sign;
                        if (bus.in_mag != '0) begin
                            state        <= S_FIRE;
                            bus.data_out <= 1'b1;
                            bus.sign_out <= bus.in_sign;
                            busy         <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_FIRE: begin
                    state   <= S_GAP;
                    gap_cnt <= 8'(GAP);
                    busy    <= 1'b1;
                    if (remaining != '0) begin
                        remaining <= remaining - MAG_W'(1);
                    end
                end
                S_GAP: begin
                    // Terminal count at 1 yields exactly GAP low cycles.
                    if (gap_cnt <= 8'd1) begin
                        gap_cnt <= '0;
                        if (remaining != '0) begin
                            state        <= S_FIRE;
                            bus.data_out <= 1'b1;
                            bus.sign_out <= sign_q;
                            busy         <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder: GAP=1 and GAP=2 instances share stimulus,
// per-cycle output traces are compared against hand-derived bit patterns.
module tb_spike_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_sign;
    logic [3:0] in_mag;
    logic       busy1, done1, busy2, done2;

    always #5 clk = ~clk;

    spike_encoder_if #(.MAG_W(4)) bus1 ();
    spike_encoder_if #(.MAG_W(4)) bus2 ();

    assign bus1.in_valid = in_valid;
    assign bus1.in_mag   = in_mag;
    assign bus1.in_sign  = in_sign;
    assign bus2.in_valid = in_valid;
    assign bus2.in_mag   = in_mag;
    assign bus2.in_sign  = in_sign;

    spike_encoder #(.MAG_W(4), .GAP(1)) u_gap1 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus1),
        .busy  (busy1),
        .done  (done1)
    );

    spike_encoder #(.MAG_W(4), .GAP(2)) u_gap2 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus2),
        .busy  (busy2),
        .done  (done2)
    );

    int n_err = 0;
    int n_chk = 0;

    logic [15:0] tr_d1, tr_s1, tr_b1, tr_dn1, tr_r1;
    logic [15:0] tr_d2, tr_s2, tr_b2, tr_dn2, tr_r2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic clear_tr();
        tr_d1 = '0; tr_s1 = '0; tr_b1 = '0; tr_dn1 = '0; tr_r1 = '0;
        tr_d2 = '0; tr_s2 = '0; tr_b2 = '0; tr_dn2 = '0; tr_r2 = '0;
    endtask

    // Oldest sample ends up in the most significant used bit.
    task automatic step();
        @(negedge clk);
        tr_d1  = {tr_d1[14:0],  bus1.data_out};
        tr_s1  = {tr_s1[14:0],  bus1.sign_out};
        tr_b1  = {tr_b1[14:0],  busy1};
        tr_dn1 = {tr_dn1[14:0], done1};
        tr_r1  = {tr_r1[14:0],  bus1.in_ready};
        tr_d2  = {tr_d2[14:0],  bus2.data_out};
        tr_s2  = {tr_s2[14:0],  bus2.sign_out};
        tr_b2  = {tr_b2[14:0],  busy2};
        tr_dn2 = {tr_dn2[14:0], done2};
        tr_r2  = {tr_r2[14:0],  bus2.in_ready};
    endtask

    task automatic quiesce();
        in_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
    endtask

    task automatic launch(input logic [3:0] m, input logic s);
        clear_tr();
        in_valid = 1'b1;
        in_mag   = m;
        in_sign  = s;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b1;
        in_mag   = 4'd7;
        in_sign  = 1'b1;
        clear_tr();

        #2;
        check("rst_data", bus1.data_out, 0);
        check("rst_sign", bus1.sign_out, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_ready", bus1.in_ready, 1);
        @(posedge clk);
        #1 check("rst_no_take", busy1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("rst_rel_busy", busy1, 0);

        // GAP=1, M=3, positive: F G F G F G D I
        quiesce();
        launch(4'd3, 1'b1);
        repeat (8) step();
        check("t1_data",  tr_d1,  32'b10101000);
        check("t1_sign",  tr_s1,  32'b10101000);
        check("t1_busy",  tr_b1,  32'b11111100);
        check("t1_done",  tr_dn1, 32'b00000010);
        check("t1_ready", tr_r1,  32'b00000011);

        // GAP=2, M=2, negative: F G G F G G D I
        quiesce();
        launch(4'd2, 1'b0);
        repeat (8) step();
        check("t2_data",  tr_d2,  32'b10010000);
        check("t2_sign",  tr_s2,  32'b00000000);
        check("t2_busy",  tr_b2,  32'b11111100);
        check("t2_done",  tr_dn2, 32'b00000010);
        check("t2_ready", tr_r2,  32'b00000011);

        // M=0 on both: D I I I
        quiesce();
        launch(4'd0, 1'b1);
        repeat (4) step();
        check("t3_g1_data",  tr_d1,  32'b0000);
        check("t3_g1_busy",  tr_b1,  32'b0000);
        check("t3_g1_done",  tr_dn1, 32'b1000);
        check("t3_g1_ready", tr_r1,  32'b1111);
        check("t3_g2_data",  tr_d2,  32'b0000);
        check("t3_g2_busy",  tr_b2,  32'b0000);
        check("t3_g2_done",  tr_dn2, 32'b1000);
        check("t3_g2_ready", tr_r2,  32'b1111);

        // GAP=1 back-to-back: M=1, second value M=2 taken in the DONE cycle
        quiesce();
        launch(4'd1, 1'b1);
        repeat (3) step();
        in_valid = 1'b1;
        in_mag   = 4'd2;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        check("t4_data",  tr_d1,  32'b100101000);
        check("t4_sign",  tr_s1,  32'b100101000);
        check("t4_busy",  tr_b1,  32'b110111100);
        check("t4_done",  tr_dn1, 32'b001000010);
        check("t4_ready", tr_r1,  32'b001000011);

        // GAP=1, M=15, flush in the gap after the third pulse
        quiesce();
        launch(4'd15, 1'b1);
        repeat (6) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (3) step();
        check("t5_data",  tr_d1,  32'b1010100000);
        check("t5_busy",  tr_b1,  32'b1111110000);
        check("t5_done",  tr_dn1, 32'b0000000000);
        check("t5_ready", tr_r1,  32'b0000000111);

        // flush together with in_valid in IDLE must not transfer
        flush    = 1'b1;
        in_valid = 1'b1;
        in_mag   = 4'd3;
        #1 check("t5_flush_ready", bus1.in_ready, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t5_flush_busy", busy1, 0);
        check("t5_flush_data", bus1.data_out, 0);
        step();
        check("t5_flush_busy2", busy1, 0);
        check("t5_flush_done2", done1, 0);

        // async reset during a pulse
        quiesce();
        launch(4'd5, 1'b1);
        step();
        check("t6_pulse_data", bus1.data_out, 1);
        check("t6_pulse_sign", bus1.sign_out, 1);
        check("t6_pulse_busy", busy1, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_data",  bus1.data_out, 0);
        check("t6_rst_sign",  bus1.sign_out, 0);
        check("t6_rst_busy",  busy1, 0);
        check("t6_rst_ready", bus1.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_tr();
        repeat (8) step();
        check("t6_after_data", tr_d1,  32'b00000000);
        check("t6_after_busy", tr_b1,  32'b00000000);
        check("t6_after_done", tr_dn1, 32'b00000000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
